pipeline_scoreboard: RTL and testbench
======================================

# pipeline_scoreboard

Parametrised hazard scoreboard for the in-order RISC-V pipeline. It sits beside the decode stage and tracks the destination register of every in-flight instruction between issue (ID→EX) and writeback. It produces a decode stall on unresolvable read-after-write (RAW) hazards and a per-operand forwarding-source select. It also applies branch flushes and global holds, and keeps saturating stall and flush performance counters.

## Interface
- `DEPTH`, default 3: in-flight stages tracked, from index 0 (EX) to index DEPTH-1 (WB). Legal range 2..8.
- `REG_W`, default 5: register index width.
- `FWD_EN`, default 1: 1 = forwarding present; 0 = every RAW match stalls.
- `ALU_READY`, default 0: lowest stage index whose non-load result is forwardable.
- `LOAD_READY`, default 1: lowest stage index whose load result is forwardable. Must be ≥ ALU_READY.
- `FLUSH_DEPTH`, default 1: number of youngest entries, stages 0..FLUSH_DEPTH-1, killed by a flush.
- `CNT_W`, default 32: performance counter width.
- `FSEL_W` (localparam): $clog2(DEPTH+1).

Ports:
- `i_clk` in 1: clock. One clock domain.
- `i_reset` in 1: reset, synchronous and active-high.
- `i_id_valid` in 1: decode holds a valid instruction.
- `i_rs1`, `i_rs2` in REG_W: source register indices.
- `i_rs1_used`, `i_rs2_used` in 1: the source operand is actually read.
- `i_rd` in REG_W: destination register index.
- `i_rd_we` in 1: the instruction writes rd.
- `i_is_load` in 1: the instruction is a load.
- `i_hold` in 1: global freeze, e.g. a memory wait.
- `i_flush` in 1: branch taken / redirect.
- `o_stall` out 1: hold IF/ID and inject a bubble into EX.
- `o_fwd_sel_rs1`, `o_fwd_sel_rs2` out FSEL_W: 0 = register file; k = forward from stage k-1.
- `o_stall_cnt`, `o_flush_cnt` out CNT_W: saturating event counters.

## Operation
- State: DEPTH entries, each holding {valid, rd, we, load}. Entry 0 is the youngest.
- Match rule: operand x matches entry s when all of the following hold: entry valid, entry we, entry rd == rs_x, rs_x_used, i_id_valid, rs_x != 0. Register x0 never matches.
- Resolution, per operand: take the lowest-index matching entry s.
  - If none: sel = 0, no hazard.
  - If FWD_EN=0: hazard.
  - If load and s < LOAD_READY: hazard.
  - If non-load and s < ALU_READY: hazard.
  - Otherwise: sel = s+1.
- While a hazard exists, sel is still driven as computed but is don't-care.
- o_stall = i_hold OR hazard(rs1) OR hazard(rs2). A hazard is only evaluated when i_id_valid is high.
- Advance (posedge, i_hold=0):
  - entry[s] ← entry[s-1] for s ≥ 1.
  - entry[0] ← {i_id_valid & ~o_stall & ~i_flush, i_rd, i_rd_we, i_is_load}.
  - The oldest entry retires.
- Hold (i_hold=1): all entries keep their values.
- Flush (i_flush=1), applied after shift or hold:
  - entries at stages 0..FLUSH_DEPTH-1 of the next state are invalidated;
  - the incoming ID instruction is never inserted.
  - Flush takes priority over hold and stall.
- Counters:
  - o_stall_cnt increments on each cycle with o_stall=1 and i_id_valid=1.
  - o_flush_cnt increments on each cycle with i_flush=1.
  - Both saturate at all-ones and never wrap.

## Timing
- o_stall and o_fwd_sel_* are combinational from registered entries plus the current decode inputs. Zero-cycle latency.
- Entries and counters update on the rising edge of i_clk only.
- Reset: while i_reset=1, at each edge all entries become invalid and both counters become 0. Reset overrides hold and flush.
- Outputs after reset: o_stall = i_hold, o_fwd_sel_* = 0, counters = 0.
- Reset asserted mid-stall discards all in-flight entries. The first post-reset cycle has no hazards.
- A producer issued at edge N is in stage s during cycle N+s. It no longer matches from cycle N+DEPTH onward.
- The register file is not write-through, so a WB-stage match is still reported: sel = DEPTH.
- Simultaneous hazard and flush: no entry is inserted; o_stall still reflects the hazard; the flush is counted.
- Stall-counter saturation at all-ones holds through further events until reset.

## Test plan
- **Forward from EX.** Defaults. Issue `add x5` (rd=5, we=1); next cycle decode rs1=5, used → o_stall=0, o_fwd_sel_rs1=1. One cycle later without a new producer, the same decode → sel=2.
- **Load-use.** Defaults. Issue `ld x7`; next cycle decode rs2=7 → o_stall=1 for exactly one cycle, then sel_rs2=2; o_stall_cnt=1.
- **x0 and unused operands.** Defaults. Producer rd=0 with we=1, then consumer rs1=0 → no stall, sel=0. Producer rd=3, consumer rs1=3 with rs1_used=0 → sel=0.
- **FWD_EN=0, DEPTH=3.** Issue `add x9`, then consumer rs1=9 → o_stall for 3 cycles; on the 4th cycle sel=0 and the instruction issues; o_stall_cnt=3.
- **Flush with hold.** Fill entries with rd=1,2,3 (stage 0 = rd 3). Assert i_flush and i_hold together → the rd=3 entry is invalid and the others are unchanged. A consumer of rs1=3 then gets sel=0; a consumer of rs1=2 gets sel=2. o_flush_cnt=1.
- **Reset and saturation.** CNT_W=4: hold o_stall with i_id_valid for 20 cycles → o_stall_cnt=15. Assert i_reset for one cycle mid-stall → entries invalid, both counters 0, sel=0.

Source files
------------

// File: rtl/pipeline_scoreboard.sv
// Hazard scoreboard for the in-order pipeline: tracks in-flight destination
// registers from EX (stage 0) to WB (stage DEPTH-1), raises a decode stall on
// unresolvable RAW hazards and picks a forwarding source per operand.
module pipeline_scoreboard #(
  parameter int DEPTH       = 3,
  parameter int REG_W       = 5,
  parameter int FWD_EN      = 1,
  parameter int ALU_READY   = 0,
  parameter int LOAD_READY  = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 32,
  localparam int FSEL_W     = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [REG_W-1:0]  i_rs1,
  input  logic [REG_W-1:0]  i_rs2,
  input  logic              i_rs1_used,
  input  logic              i_rs2_used,
  input  logic [REG_W-1:0]  i_rd,
  input  logic              i_rd_we,
  input  logic              i_is_load,
  input  logic              i_hold,
  input  logic              i_flush,
  output logic              o_stall,
  output logic [FSEL_W-1:0] o_fwd_sel_rs1,
  output logic [FSEL_W-1:0] o_fwd_sel_rs2,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  // In-flight entries; index 0 is the youngest (EX), DEPTH-1 the oldest (WB).
  logic             ent_vld [DEPTH];
  logic [REG_W-1:0] ent_rd  [DEPTH];
  logic             ent_we  [DEPTH];
  logic             ent_ld  [DEPTH];
  logic             nxt_vld [DEPTH];

  logic hit1, hit2, ld1, ld2, hz1, hz2;
  int   idx1, idx2;

  // A match at stage idx is unresolvable when forwarding is absent or the
  // producer's result is not yet available at that stage.
  function automatic logic is_hazard(input logic hit, input logic ld, input int idx);
    if (!hit)        return 1'b0;
    if (FWD_EN == 0) return 1'b1;
    if (ld)          return (idx < LOAD_READY);
    return (idx < ALU_READY);
  endfunction

  // Stage k-1 is encoded as select k so that 0 always means the register file.
  function automatic logic [FSEL_W-1:0] fwd_sel(input logic hit, input int idx);
    return hit ? FSEL_W'(idx + 1) : '0;
  endfunction

  // Saturating increment: sticks at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Find the youngest matching producer for each operand (scan old to young
  // so the lowest index wins); x0 and unread operands never match.
  always_comb begin
    hit1 = 1'b0; idx1 = 0; ld1 = 1'b0;
    hit2 = 1'b0; idx2 = 0; ld2 = 1'b0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (ent_vld[s] && ent_we[s] && (ent_rd[s] == i_rs1) && i_rs1_used &&
          i_id_valid && (i_rs1 != '0)) begin
        hit1 = 1'b1; idx1 = s; ld1 = ent_ld[s];
      end
      if (ent_vld[s] && ent_we[s] && (ent_rd[s] == i_rs2) && i_rs2_used &&
          i_id_valid && (i_rs2 != '0)) begin
        hit2 = 1'b1; idx2 = s; ld2 = ent_ld[s];
      end
    end
  end

  // Stall and forwarding selects are purely combinational from the entries.
  always_comb begin
    hz1           = is_hazard(hit1, ld1, idx1);
    hz2           = is_hazard(hit2, ld2, idx2);
    o_stall       = i_hold | hz1 | hz2;
    o_fwd_sel_rs1 = fwd_sel(hit1, idx1);
    o_fwd_sel_rs2 = fwd_sel(hit2, idx2);
  end

  // Next valid bits: shift unless held, then let a flush kill the youngest
  // FLUSH_DEPTH slots; a flushed cycle never inserts the decode instruction.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) nxt_vld[s] = ent_vld[s];
    if (!i_hold) begin
      for (int s = DEPTH - 1; s >= 1; s--) nxt_vld[s] = ent_vld[s-1];
      nxt_vld[0] = i_id_valid & ~o_stall & ~i_flush;
    end
    if (i_flush) begin
      for (int s = 0; s < FLUSH_DEPTH && s < DEPTH; s++) nxt_vld[s] = 1'b0;
    end
  end

  // Valid bits and counters are control state and take the reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < DEPTH; s++) ent_vld[s] <= 1'b0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) ent_vld[s] <= nxt_vld[s];
      if (o_stall && i_id_valid) o_stall_cnt <= sat_inc(o_stall_cnt);
      if (i_flush)               o_flush_cnt <= sat_inc(o_flush_cnt);
    end
  end

  // Entry payload shifts with the pipeline; it is qualified by ent_vld so it
  // needs no reset.
  always_ff @(posedge i_clk) begin
    if (!i_hold) begin
      for (int s = DEPTH - 1; s >= 1; s--) begin
        ent_rd[s] <= ent_rd[s-1];
        ent_we[s] <= ent_we[s-1];
        ent_ld[s] <= ent_ld[s-1];
      end
      ent_rd[0] <= i_rd;
      ent_we[0] <= i_rd_we;
      ent_ld[0] <= i_is_load;
    end
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard: three instances share the stimulus
// (defaults, no forwarding, 4-bit counters); each test reads the instance it
// targets.
module tb_pipeline_scoreboard;

  logic       clk = 1'b0;
  logic       reset, id_valid, rs1_used, rs2_used, rd_we, is_load, hold, flush;
  logic [4:0] rs1, rs2, rd;

  logic        def_stall, nf_stall, c4_stall;
  logic [1:0]  def_sel1, def_sel2, nf_sel1, nf_sel2, c4_sel1, c4_sel2;
  logic [31:0] def_scnt, def_fcnt, nf_scnt, nf_fcnt;
  logic [3:0]  c4_scnt, c4_fcnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_scoreboard u_def (
    .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_rs1(rs1), .i_rs2(rs2),
    .i_rs1_used(rs1_used), .i_rs2_used(rs2_used), .i_rd(rd), .i_rd_we(rd_we),
    .i_is_load(is_load), .i_hold(hold), .i_flush(flush), .o_stall(def_stall),
    .o_fwd_sel_rs1(def_sel1), .o_fwd_sel_rs2(def_sel2),
    .o_stall_cnt(def_scnt), .o_flush_cnt(def_fcnt)
  );

  pipeline_scoreboard #(.FWD_EN(0)) u_nf (
    .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_rs1(rs1), .i_rs2(rs2),
    .i_rs1_used(rs1_used), .i_rs2_used(rs2_used), .i_rd(rd), .i_rd_we(rd_we),
    .i_is_load(is_load), .i_hold(hold), .i_flush(flush), .o_stall(nf_stall),
    .o_fwd_sel_rs1(nf_sel1), .o_fwd_sel_rs2(nf_sel2),
    .o_stall_cnt(nf_scnt), .o_flush_cnt(nf_fcnt)
  );

  pipeline_scoreboard #(.CNT_W(4)) u_c4 (
    .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_rs1(rs1), .i_rs2(rs2),
    .i_rs1_used(rs1_used), .i_rs2_used(rs2_used), .i_rd(rd), .i_rd_we(rd_we),
    .i_is_load(is_load), .i_hold(hold), .i_flush(flush), .o_stall(c4_stall),
    .o_fwd_sel_rs1(c4_sel1), .o_fwd_sel_rs2(c4_sel2),
    .o_stall_cnt(c4_scnt), .o_flush_cnt(c4_fcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    rd = '0; rd_we = 1'b0; is_load = 1'b0; hold = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    id_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2; rs1_used = 1'b1; rs2_used = 1'b1;
    #1;
    n_cmp++; if (def_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", def_stall); end
    n_cmp++; if (def_sel1 !== 2'd0) begin n_bad++; $display("FAIL reset_sel1: got %0d want 0", def_sel1); end
    n_cmp++; if (def_sel2 !== 2'd0) begin n_bad++; $display("FAIL reset_sel2: got %0d want 0", def_sel2); end
    n_cmp++; if (def_scnt !== 32'd0) begin n_bad++; $display("FAIL reset_scnt: got %0d want 0", def_scnt); end
    n_cmp++; if (def_fcnt !== 32'd0) begin n_bad++; $display("FAIL reset_fcnt: got %0d want 0", def_fcnt); end
    hold = 1'b1;
    #1;
    n_cmp++; if (def_stall !== 1'b1) begin n_bad++; $display("FAIL reset_hold_stall: got %0d want 1", def_stall); end
    idle();
  endtask

  task automatic test_fwd_ex();
    do_reset();
    id_valid = 1'b1; rd = 5'd5; rd_we = 1'b1;
    tick();
    rd = 5'd0; rd_we = 1'b0; rs1 = 5'd5; rs1_used = 1'b1;
    #1;
    n_cmp++; if (def_stall !== 1'b0) begin n_bad++; $display("FAIL fwd_ex_stall: got %0d want 0", def_stall); end
    n_cmp++; if (def_sel1 !== 2'd1) begin n_bad++; $display("FAIL fwd_ex_sel: got %0d want 1", def_sel1); end
    tick();
    n_cmp++; if (def_sel1 !== 2'd2) begin n_bad++; $display("FAIL fwd_mem_sel: got %0d want 2", def_sel1); end
    tick();
    n_cmp++; if (def_sel1 !== 2'd3) begin n_bad++; $display("FAIL fwd_wb_sel: got %0d want 3", def_sel1); end
    tick();
    n_cmp++; if (def_sel1 !== 2'd0) begin n_bad++; $display("FAIL fwd_retired_sel: got %0d want 0", def_sel1); end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    id_valid = 1'b1; rd = 5'd7; rd_we = 1'b1; is_load = 1'b1;
    tick();
    rd = 5'd0; rd_we = 1'b0; is_load = 1'b0; rs2 = 5'd7; rs2_used = 1'b1;
    #1;
    n_cmp++; if (def_stall !== 1'b1) begin n_bad++; $display("FAIL load_use_stall: got %0d want 1", def_stall); end
    tick();
    n_cmp++; if (def_stall !== 1'b0) begin n_bad++; $display("FAIL load_use_release: got %0d want 0", def_stall); end
    n_cmp++; if (def_sel2 !== 2'd2) begin n_bad++; $display("FAIL load_use_sel2: got %0d want 2", def_sel2); end
    n_cmp++; if (def_scnt !== 32'd1) begin n_bad++; $display("FAIL load_use_scnt: got %0d want 1", def_scnt); end
    idle();
  endtask

  task automatic test_x0_unused();
    do_reset();
    id_valid = 1'b1; rd = 5'd0; rd_we = 1'b1;
    tick();
    rs1 = 5'd0; rs1_used = 1'b1; rd = 5'd3; rd_we = 1'b1;
    #1;
    n_cmp++; if (def_stall !== 1'b0) begin n_bad++; $display("FAIL x0_stall: got %0d want 0", def_stall); end
    n_cmp++; if (def_sel1 !== 2'd0) begin n_bad++; $display("FAIL x0_sel1: got %0d want 0", def_sel1); end
    tick();
    rd = 5'd0; rd_we = 1'b0; rs1 = 5'd3; rs1_used = 1'b0;
    #1;
    n_cmp++; if (def_sel1 !== 2'd0) begin n_bad++; $display("FAIL unused_sel1: got %0d want 0", def_sel1); end
    rs1_used = 1'b1; rs2 = 5'd3; rs2_used = 1'b1;
    #1;
    n_cmp++; if (def_sel1 !== 2'd1) begin n_bad++; $display("FAIL used_sel1: got %0d want 1", def_sel1); end
    n_cmp++; if (def_sel2 !== 2'd1) begin n_bad++; $display("FAIL used_sel2: got %0d want 1", def_sel2); end
    id_valid = 1'b0;
    #1;
    n_cmp++; if (def_sel1 !== 2'd0) begin n_bad++; $display("FAIL novalid_sel1: got %0d want 0", def_sel1); end
    idle();
  endtask

  task automatic test_no_fwd();
    do_reset();
    id_valid = 1'b1; rd = 5'd9; rd_we = 1'b1;
    tick();
    rd = 5'd0; rd_we = 1'b0; rs1 = 5'd9; rs1_used = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (nf_stall !== 1'b1) begin n_bad++; $display("FAIL nofwd_stall_c%0d: got %0d want 1", c, nf_stall); end
      tick();
    end
    n_cmp++; if (nf_stall !== 1'b0) begin n_bad++; $display("FAIL nofwd_release: got %0d want 0", nf_stall); end
    n_cmp++; if (nf_sel1 !== 2'd0) begin n_bad++; $display("FAIL nofwd_sel1: got %0d want 0", nf_sel1); end
    n_cmp++; if (nf_scnt !== 32'd3) begin n_bad++; $display("FAIL nofwd_scnt: got %0d want 3", nf_scnt); end
    idle();
  endtask

  task automatic test_flush_hold();
    do_reset();
    id_valid = 1'b1; rd_we = 1'b1;
    rd = 5'd1; tick();
    rd = 5'd2; tick();
    rd = 5'd3; tick();
    rd = 5'd9; hold = 1'b1; flush = 1'b1;
    #1;
    n_cmp++; if (def_stall !== 1'b1) begin n_bad++; $display("FAIL flush_hold_stall: got %0d want 1", def_stall); end
    tick();
    hold = 1'b0; flush = 1'b0; rd = 5'd0; rd_we = 1'b0;
    rs1 = 5'd3; rs1_used = 1'b1; rs2 = 5'd2; rs2_used = 1'b1;
    #1;
    n_cmp++; if (def_sel1 !== 2'd0) begin n_bad++; $display("FAIL flush_killed_sel1: got %0d want 0", def_sel1); end
    n_cmp++; if (def_sel2 !== 2'd2) begin n_bad++; $display("FAIL flush_kept_sel2: got %0d want 2", def_sel2); end
    n_cmp++; if (def_stall !== 1'b0) begin n_bad++; $display("FAIL flush_after_stall: got %0d want 0", def_stall); end
    n_cmp++; if (def_fcnt !== 32'd1) begin n_bad++; $display("FAIL flush_fcnt: got %0d want 1", def_fcnt); end
    rs1 = 5'd1;
    #1;
    n_cmp++; if (def_sel1 !== 2'd3) begin n_bad++; $display("FAIL flush_oldest_sel1: got %0d want 3", def_sel1); end
    rs1 = 5'd9;
    #1;
    n_cmp++; if (def_sel1 !== 2'd0) begin n_bad++; $display("FAIL flush_noinsert_sel1: got %0d want 0", def_sel1); end
    idle();
  endtask

  task automatic test_flush_hazard();
    do_reset();
    id_valid = 1'b1; rd = 5'd4; rd_we = 1'b1; is_load = 1'b1;
    tick();
    is_load = 1'b0; rd = 5'd6; rs1 = 5'd4; rs1_used = 1'b1; flush = 1'b1;
    #1;
    n_cmp++; if (def_stall !== 1'b1) begin n_bad++; $display("FAIL flhz_stall: got %0d want 1", def_stall); end
    tick();
    flush = 1'b0; rd = 5'd0; rd_we = 1'b0; rs2 = 5'd6; rs2_used = 1'b1;
    #1;
    n_cmp++; if (def_sel1 !== 2'd2) begin n_bad++; $display("FAIL flhz_sel1: got %0d want 2", def_sel1); end
    n_cmp++; if (def_sel2 !== 2'd0) begin n_bad++; $display("FAIL flhz_sel2: got %0d want 0", def_sel2); end
    n_cmp++; if (def_fcnt !== 32'd1) begin n_bad++; $display("FAIL flhz_fcnt: got %0d want 1", def_fcnt); end
    n_cmp++; if (def_scnt !== 32'd1) begin n_bad++; $display("FAIL flhz_scnt: got %0d want 1", def_scnt); end
    idle();
  endtask

  task automatic test_sat_reset();
    do_reset();
    id_valid = 1'b1; rd = 5'd7; rd_we = 1'b1; is_load = 1'b1;
    tick();
    rd = 5'd0; rd_we = 1'b0; is_load = 1'b0; rs2 = 5'd7; rs2_used = 1'b1; hold = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    n_cmp++; if (c4_scnt !== 4'd15) begin n_bad++; $display("FAIL sat_c4_scnt: got %0d want 15", c4_scnt); end
    n_cmp++; if (def_scnt !== 32'd20) begin n_bad++; $display("FAIL sat_def_scnt: got %0d want 20", def_scnt); end
    n_cmp++; if (c4_sel2 !== 2'd1) begin n_bad++; $display("FAIL sat_held_sel2: got %0d want 1", c4_sel2); end
    reset = 1'b1;
    tick();
    reset = 1'b0; hold = 1'b0;
    #1;
    n_cmp++; if (c4_stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall: got %0d want 0", c4_stall); end
    n_cmp++; if (c4_sel2 !== 2'd0) begin n_bad++; $display("FAIL rst_mid_sel2: got %0d want 0", c4_sel2); end
    n_cmp++; if (c4_scnt !== 4'd0) begin n_bad++; $display("FAIL rst_mid_scnt: got %0d want 0", c4_scnt); end
    n_cmp++; if (c4_fcnt !== 4'd0) begin n_bad++; $display("FAIL rst_mid_fcnt: got %0d want 0", c4_fcnt); end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_x0_unused();
    test_no_fwd();
    test_flush_hold();
    test_flush_hazard();
    test_sat_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
